// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
package lsu_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned SIZE_W = 2;

  localparam logic [SIZE_W-1:0] SZ_BYTE = 2'b00;
  localparam logic [SIZE_W-1:0] SZ_HALF = 2'b01;
  localparam logic [SIZE_W-1:0] SZ_WORD = 2'b10;
  localparam logic [SIZE_W-1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    SPLIT  = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Natural alignment check for the legal sizes.
  function automatic logic is_aligned(input logic [SIZE_W-1:0] size,
                                      input logic [1:0]        addr_lo);
    logic ok;
    ok = 1'b1;
    if (size == SZ_HALF) ok = (addr_lo[0] == 1'b0);
    if (size == SZ_WORD) ok = (addr_lo == 2'b00);
    return ok;
  endfunction

  // Index of the final byte of a split access.
  function automatic logic [1:0] last_idx(input logic [SIZE_W-1:0] size);
    return (size == SZ_WORD) ? 2'd3 : 2'd1;
  endfunction

  // Big-endian byte i of right-justified store data.
  function automatic logic [BYTE_W-1:0] split_byte(input logic [31:0]       wdata,
                                                   input logic [SIZE_W-1:0] size,
                                                   input logic [1:0]        idx);
    logic [1:0] sel;
    sel = last_idx(size) - idx;
    return wdata[{sel, 3'b000} +: BYTE_W];
  endfunction

endpackage

// File: rtl/lsu_load_format.sv
// Zero/sign extension of a right-justified raw load value by access size.
module lsu_load_format
  import lsu_pkg::*;
(
  input  logic [31:0]       raw,
  input  logic [SIZE_W-1:0] size,
  input  logic              sign_ext,
  output logic [31:0]       rdata_c
);

  // Extend byte/halfword results; words pass through.
  always_comb begin
    rdata_c = raw;
    case (size)
      SZ_BYTE: rdata_c = {{24{sign_ext & raw[7]}}, raw[7:0]};
      SZ_HALF: rdata_c = {{16{sign_ext & raw[15]}}, raw[15:0]};
      default: rdata_c = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator of the DataMemory port between MEM stage and memory.
// Optional feature: LSU_MISALIGN_SPLIT_EN splits misaligned half/word accesses
// into byte accesses; without it misaligned requests return an error.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [SIZE_W-1:0] req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_di,
  output logic [SIZE_W-1:0] mem_size,
  output logic              mem_rw,
  output logic              mem_e,
  output logic              mem_se,
  input  logic [DATA_W-1:0] mem_do
);

  state_e              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
  logic [DATA_W-1:0]   mem_di_q, mem_di_d;
  logic [SIZE_W-1:0]   mem_size_q, mem_size_d;
  logic                mem_rw_q, mem_rw_d;
  logic                mem_e_q, mem_e_d;
  logic                store_q, store_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic                signed_q, signed_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          idx_q, idx_d;
  logic [23:0]         raw_q, raw_d;
  logic [31:0]         fmt_raw_c;
  logic [31:0]         fmt_rdata_c;

  // Raw load value: direct memory read, or the split bytes assembled big-endian.
  assign fmt_raw_c = (state_q == SPLIT) ? {raw_q, mem_do[7:0]} : 32'(mem_do);

  lsu_load_format u_load_format (
    .raw      (fmt_raw_c),
    .size     (size_q),
    .sign_ext (signed_q),
    .rdata_c  (fmt_rdata_c)
  );

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    mem_e_d     = 1'b0;
    mem_a_d     = mem_a_q;
    mem_di_d    = mem_di_q;
    mem_size_d  = mem_size_q;
    mem_rw_d    = mem_rw_q;
    store_d     = store_q;
    size_d      = size_q;
    signed_d    = signed_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    idx_d       = idx_q;
    raw_d       = raw_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          store_d  = req_store;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          idx_d    = 2'd0;
          raw_d    = 24'd0;
          if (req_size == SZ_ILL) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (is_aligned(req_size, req_addr[1:0])) begin
            state_d    = ACCESS;
            mem_e_d    = 1'b1;
            mem_a_d    = req_addr;
            mem_size_d = req_size;
            mem_rw_d   = req_store;
            if (req_store) mem_di_d = req_wdata;
          end else begin
`ifdef LSU_MISALIGN_SPLIT_EN
            state_d    = SPLIT;
            mem_e_d    = 1'b1;
            mem_a_d    = req_addr;
            mem_size_d = SZ_BYTE;
            mem_rw_d   = req_store;
            if (req_store) mem_di_d = DATA_W'(split_byte(req_wdata, req_size, 2'd0));
`else
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
`endif
          end
        end
      end

      ACCESS: begin
        state_d     = DONE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = store_q ? '0 : DATA_W'(fmt_rdata_c);
      end

      SPLIT: begin
        if (mem_e_q) begin
          // Pulse cycle: collect the byte, then finish or insert a gap cycle.
          raw_d = fmt_raw_c[23:0];
          if (idx_q == last_idx(size_q)) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = store_q ? '0 : DATA_W'(fmt_rdata_c);
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          // Gap cycle: set up the next byte access.
          mem_e_d = 1'b1;
          mem_a_d = addr_q + ADDR_W'(idx_q);
          if (store_q) mem_di_d = DATA_W'(split_byte(wdata_q, size_q, idx_q));
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_a_q     <= '0;
      mem_di_q    <= '0;
      mem_size_q  <= '0;
      mem_rw_q    <= 1'b0;
      mem_e_q     <= 1'b0;
      store_q     <= 1'b0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      idx_q       <= 2'd0;
      raw_q       <= 24'd0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_a_q     <= mem_a_d;
      mem_di_q    <= mem_di_d;
      mem_size_q  <= mem_size_d;
      mem_rw_q    <= mem_rw_d;
      mem_e_q     <= mem_e_d;
      store_q     <= store_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      idx_q       <= idx_d;
      raw_q       <= raw_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_a     = mem_a_q;
  assign mem_di    = mem_di_q;
  assign mem_size  = mem_size_q;
  assign mem_rw    = mem_rw_q;
  assign mem_e     = mem_e_q;
  // Extension is done inside the unit, so memory-side extension stays off.
  assign mem_se    = 1'b0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a byte-array DataMemory and reference model.
module tb_load_store_unit;

  localparam int unsigned ADDR_W = 9;
  localparam int          MEM_N  = 512;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_store = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_signed = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_a;
  logic [31:0]       mem_di;
  logic [1:0]        mem_size;
  logic              mem_rw;
  logic              mem_e;
  logic              mem_se;
  logic [31:0]       mem_do;

  load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_a(mem_a), .mem_di(mem_di), .mem_size(mem_size),
    .mem_rw(mem_rw), .mem_e(mem_e), .mem_se(mem_se), .mem_do(mem_do)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  function automatic logic [7:0] init_byte(input int i);
    logic [31:0] pre;
    pre = 32'hA1B2C3D4;
    if (i < 4) return pre[31 - 8*i -: 8];
    return 8'((i * 37 + 5) & 255);
  endfunction

  // DataMemory: big-endian, combinational read, write on the clock edge while E and R_W.
  logic [7:0] mem [MEM_N];
  bit         preloaded;

  function automatic int wrap(input int a);
    return a % MEM_N;
  endfunction

  always_comb begin
    case (mem_size)
      2'b00:   mem_do = {24'h0, mem[int'(mem_a)]};
      2'b01:   mem_do = {16'h0, mem[int'(mem_a)], mem[wrap(int'(mem_a) + 1)]};
      2'b10:   mem_do = {mem[int'(mem_a)], mem[wrap(int'(mem_a) + 1)],
                         mem[wrap(int'(mem_a) + 2)], mem[wrap(int'(mem_a) + 3)]};
      default: mem_do = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < MEM_N; i++) mem[i] <= init_byte(i);
      preloaded <= 1'b1;
    end else if (mem_e && mem_rw) begin
      case (mem_size)
        2'b00: mem[int'(mem_a)] <= mem_di[7:0];
        2'b01: begin
          mem[int'(mem_a)]              <= mem_di[15:8];
          mem[wrap(int'(mem_a) + 1)]    <= mem_di[7:0];
        end
        2'b10: begin
          mem[int'(mem_a)]              <= mem_di[31:24];
          mem[wrap(int'(mem_a) + 1)]    <= mem_di[23:16];
          mem[wrap(int'(mem_a) + 2)]    <= mem_di[15:8];
          mem[wrap(int'(mem_a) + 3)]    <= mem_di[7:0];
        end
        default: ;
      endcase
    end
  end

  // Reference model: flat byte array plus the access rules.
  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          pulses;
    int          lat;
  } exp_t;

  logic [7:0] ref_mem [MEM_N];
  exp_t       sbq [$];

  function automatic exp_t model(input logic st, input logic [1:0] sz, input logic sg,
                                 input int addr, input logic [31:0] wd);
    exp_t   e;
    int     n;
    longint v;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 0;
    e.err = 1'b0; e.rdata = 32'h0; e.pulses = 0; e.lat = -1;
    if (n == 0 || ((addr % n) != 0 && !SPLIT_EN)) begin
      e.err = 1'b1;
      return e;
    end
    if ((addr % n) == 0) begin
      e.pulses = 1;
      e.lat    = 1;  // rsp_valid one edge after the cycle in which E is high
    end else begin
      e.pulses = n;
    end
    if (st) begin
      for (int i = 0; i < n; i++)
        ref_mem[(addr + i) % MEM_N] = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = v * 256 + longint'(ref_mem[(addr + i) % MEM_N]);
      if (sg && n < 4 && v >= (64'sd1 <<< (8 * n - 1))) v = v - (64'sd1 <<< (8 * n));
      e.rdata = 32'(v);
    end
    return e;
  endfunction

  // Monitor: accept time on the clock edge, response checks on the falling edge.
  int   cyc = 0;
  int   acc_cyc = -100;
  int   ecount = 0;
  exp_t mon_e;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset_n && req_valid && req_ready) acc_cyc = cyc;
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (cyc == acc_cyc) ecount = 0;
      if (mem_e) ecount = ecount + 1;
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          fail_now("unexpected_rsp_valid");
        end else begin
          mon_e = sbq.pop_front();
          chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
          chk("rsp_rdata", rsp_rdata, mon_e.rdata);
          chk("mem_e_pulses", 32'(ecount), 32'(mon_e.pulses));
          if (mon_e.lat >= 0) chk("rsp_latency", 32'(cyc - acc_cyc), 32'(mon_e.lat));
          chk("req_ready_low_at_rsp", 32'(req_ready), 32'h0);
          chk("mem_se", 32'(mem_se), 32'h0);
        end
      end
    end
  end

  task automatic issue(input logic st, input logic [1:0] sz, input logic sg,
                       input int addr, input logic [31:0] wd, input bit expect_rsp);
    exp_t e;
    int   t;
    if (expect_rsp) begin
      e = model(st, sz, sg, addr, wd);
      sbq.push_back(e);
    end
    @(negedge clk);
    req_store  = st;
    req_size   = sz;
    req_signed = sg;
    req_addr   = ADDR_W'(addr);
    req_wdata  = wd;
    req_valid  = 1'b1;
    t = 0;
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) fail_now("accept_timeout");
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sbq.size() != 0) fail_now("response_timeout");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < MEM_N; i++) ref_mem[i] = init_byte(i);
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'h1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_err", 32'(rsp_err), 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_mem_e", 32'(mem_e), 32'h0);
    chk("reset_mem_rw", 32'(mem_rw), 32'h0);
    chk("reset_mem_a", 32'(mem_a), 32'h0);
    chk("reset_mem_di", mem_di, 32'h0);
    chk("reset_mem_size", 32'(mem_size), 32'h0);
    chk("reset_mem_se", 32'(mem_se), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed sequence.
    issue(1'b0, 2'b10, 1'b0, 0,   32'h0,        1'b1); wait_idle();
    issue(1'b0, 2'b00, 1'b1, 0,   32'h0,        1'b1); wait_idle();
    issue(1'b0, 2'b00, 1'b0, 0,   32'h0,        1'b1); wait_idle();
    issue(1'b0, 2'b01, 1'b1, 2,   32'h0,        1'b1); wait_idle();
    issue(1'b1, 2'b10, 1'b0, 8,   32'h12345678, 1'b1); wait_idle();
    issue(1'b0, 2'b10, 1'b0, 8,   32'h0,        1'b1); wait_idle();
    issue(1'b1, 2'b01, 1'b0, 2,   32'h00000855, 1'b1); wait_idle();
    issue(1'b0, 2'b10, 1'b0, 0,   32'h0,        1'b1); wait_idle();
    issue(1'b0, 2'b01, 1'b0, 1,   32'h0,        1'b1); wait_idle();
    issue(1'b0, 2'b01, 1'b1, 1,   32'h0,        1'b1); wait_idle();
    issue(1'b0, 2'b11, 1'b0, 4,   32'h0,        1'b1); wait_idle();
    issue(1'b1, 2'b11, 1'b0, 4,   32'hDEADBEEF, 1'b1); wait_idle();
    issue(1'b1, 2'b10, 1'b0, 510, 32'hAABBCCDD, 1'b1); wait_idle();
    issue(1'b0, 2'b10, 1'b0, 510, 32'h0,        1'b1); wait_idle();
    issue(1'b0, 2'b00, 1'b0, 511, 32'h0,        1'b1); wait_idle();
    issue(1'b0, 2'b10, 1'b1, 508, 32'h0,        1'b1); wait_idle();

    // Randomized traffic concentrated near both ends of memory.
    for (int i = 0; i < 80; i++) begin
      int a;
      a = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(500, 511));
      issue(1'(($urandom & 1)), 2'($urandom_range(0, 3)), 1'(($urandom & 1)), a, $urandom, 1'b1);
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();

    // Reset in the middle of a store: E drops at once and no response follows.
    if (SPLIT_EN) begin
      issue(1'b1, 2'b10, 1'b0, 510, 32'hAABBCCDD, 1'b0);
      @(negedge clk);
      @(negedge clk);
    end else begin
      issue(1'b1, 2'b10, 1'b0, 508, 32'hAABBCCDD, 1'b0);
    end
    chk("abort_mem_e_before_reset", 32'(mem_e), 32'h1);
    chk("abort_mem_rw_before_reset", 32'(mem_rw), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("abort_mem_e_dropped", 32'(mem_e), 32'h0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_req_ready_after", 32'(req_ready), 32'h1);
    if (SPLIT_EN) begin
      ref_mem[510] = 8'hAA;
      chk("abort_mem510_written", 32'(mem[510]), 32'hAA);
    end else begin
      chk("abort_mem508_untouched", 32'(mem[508]), 32'(ref_mem[508]));
    end
    issue(1'b0, 2'b00, 1'b0, 510, 32'h0, 1'b1); wait_idle();
    issue(1'b0, 2'b00, 1'b0, 511, 32'h0, 1'b1); wait_idle();
    issue(1'b0, 2'b10, 1'b0, 508, 32'h0, 1'b1); wait_idle();
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
